// File: rtl/mips_cpu_pkg.sv
// Shared CPU types: ALU decoder codes, mult/div FSM states and divide-by-zero LO value.
// Pure declarations, no logic.
package mips_cpu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_NOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SLT   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_MULT  = 4'b1010,
    ALU_MULTU = 4'b1011,
    ALU_DIV   = 4'b1100,
    ALU_DIVU  = 4'b1101,
    ALU_SLTU  = 4'b1110
  } alu_control_t;

  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_DIV_RUN = 2'd1,
    MD_DIV_FIX = 2'd2
  } md_state_t;

  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFFFFFF;

endpackage

// File: rtl/serial_divider.sv
// Unsigned 32-bit restoring divider, one quotient bit per clock after i_start.
// o_last flags the final iteration; o_done pulses the cycle after results settle.
module serial_divider #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_last,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  localparam int CW = $clog2(DIV_ITERS);

  logic [CW-1:0] r_count;
  logic          r_run;
  logic          r_done;
  logic [31:0]   r_dq;
  logic [31:0]   r_rem;
  logic [31:0]   r_divisor;
  logic [32:0]   w_shift;
  logic [32:0]   w_diff;

  // r_dq starts as the dividend and fills with quotient bits from the LSB as dividend bits leave the MSB
  assign w_shift = {r_rem, r_dq[31]};
  assign w_diff  = w_shift - {1'b0, r_divisor};
  assign o_last  = r_run && (r_count == CW'(DIV_ITERS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_run     <= 1'b0;
      r_done    <= 1'b0;
      r_dq      <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_dq      <= i_dividend;
        r_divisor <= i_divisor;
        r_rem     <= '0;
        r_count   <= '0;
        r_run     <= 1'b1;
      end else if (r_run) begin
        if (!w_diff[32]) begin
          r_rem <= w_diff[31:0];
          r_dq  <= {r_dq[30:0], 1'b1};
        end else begin
          r_rem <= w_shift[31:0];
          r_dq  <= {r_dq[30:0], 1'b0};
        end
        r_count <= r_count + CW'(1);
        if (o_last) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_dq;
  assign o_remainder = r_rem;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO owner: single-cycle MULT/MULTU, 33-cycle busy DIV/DIVU, MTHI/MTLO writes.
// done pulses the cycle after HI/LO take a result; start and MT writes are dropped while busy.
module mult_div_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  alu_control,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  import mips_cpu_pkg::*;

  md_state_t   r_state;
  md_state_t   w_state_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_div0;
  logic [31:0] r_dividend_orig;

  logic        w_mul_s;
  logic        w_mul_u;
  logic        w_div_s;
  logic        w_div_u;
  logic        w_div_go;
  logic [63:0] w_prod;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_last;
  logic        w_div_done;

  assign w_mul_s  = start && (alu_control == ALU_MULT);
  assign w_mul_u  = start && (alu_control == ALU_MULTU);
  assign w_div_s  = start && (alu_control == ALU_DIV);
  assign w_div_u  = start && (alu_control == ALU_DIVU);
  assign w_div_go = (w_div_s || w_div_u) && (r_state == MD_IDLE);

  assign w_prod = w_mul_s ? ({{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b})
                          : ({32'd0, op_a} * {32'd0, op_b});

  assign w_abs_a = (w_div_s && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign w_abs_b = (w_div_s && op_b[31]) ? (~op_b + 32'd1) : op_b;

  serial_divider #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_div_go),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_last      (w_div_last),
    .o_done      (w_div_done),
    .o_quotient  (w_quot),
    .o_remainder (w_rem)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_done_nxt  = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (mthi) w_hi_nxt = op_a;
        if (mtlo) w_lo_nxt = op_a;
        // product overrides any same-cycle MT write
        if (w_mul_s || w_mul_u) begin
          {w_hi_nxt, w_lo_nxt} = w_prod;
          w_done_nxt           = 1'b1;
        end else if (w_div_go) begin
          w_state_nxt = MD_DIV_RUN;
        end
      end
      MD_DIV_RUN: begin
        if (w_div_last) w_state_nxt = MD_DIV_FIX;
      end
      MD_DIV_FIX: begin
        if (w_div_done) begin
          w_state_nxt = MD_IDLE;
          w_done_nxt  = 1'b1;
          if (r_div0) begin
            w_hi_nxt = r_dividend_orig;
            w_lo_nxt = DIV_BY_ZERO_LO;
          end else begin
            w_lo_nxt = r_q_neg ? (~w_quot + 32'd1) : w_quot;
            w_hi_nxt = r_r_neg ? (~w_rem + 32'd1) : w_rem;
          end
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= MD_IDLE;
      r_hi            <= '0;
      r_lo            <= '0;
      r_done          <= 1'b0;
      r_q_neg         <= 1'b0;
      r_r_neg         <= 1'b0;
      r_div0          <= 1'b0;
      r_dividend_orig <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_done  <= w_done_nxt;
      if (w_div_go) begin
        r_q_neg         <= w_div_s && (op_a[31] ^ op_b[31]);
        r_r_neg         <= w_div_s && op_a[31];
        r_div0          <= (op_b == 32'd0);
        r_dividend_orig <= op_a;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != MD_IDLE);
  assign done = r_done;

endmodule
